aes_cipher_iter: RTL

Iterative AES-128 encryption datapath that consumes the round keys produced by `aes_key_expansion`. It encrypts one 128-bit block per request and applies one round per enabled clock. If the round key for the current round is not yet flagged done, the block stalls on that round, so encryption can start while key expansion is still running. It sits directly downstream of key expansion and ahead of the accelerator's output/bus interface.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_round.sv | 35 +++
 rtl/aes_cipher_iter.sv | 89 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, S-box and GF(2^8) helpers; also used by aes_key_expansion.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) mod 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when i_last), AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  aes_state_t i_state,
  input  aes_state_t i_key,
  input  logic       i_last,
  output aes_state_t o_state
);

  // Byte (r,c) lives at bits [127-8*(4c+r) -: 8]
  logic [7:0] w_sr [4][4];
  logic [7:0] w_mc [4][4];
  aes_state_t w_mix;

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[r][c] = sbox(i_state[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mc[0][c] = xtime(w_sr[0][c]) ^ xtime(w_sr[1][c]) ^ w_sr[1][c] ^ w_sr[2][c] ^ w_sr[3][c];
      w_mc[1][c] = w_sr[0][c] ^ xtime(w_sr[1][c]) ^ xtime(w_sr[2][c]) ^ w_sr[2][c] ^ w_sr[3][c];
      w_mc[2][c] = w_sr[0][c] ^ w_sr[1][c] ^ xtime(w_sr[2][c]) ^ xtime(w_sr[3][c]) ^ w_sr[3][c];
      w_mc[3][c] = xtime(w_sr[0][c]) ^ w_sr[0][c] ^ w_sr[1][c] ^ w_sr[2][c] ^ xtime(w_sr[3][c]);
      for (int r = 0; r < 4; r++) begin
        w_mix[127-8*(4*c+r) -: 8] = i_last ? w_sr[r][c] : w_mc[r][c];
      end
    end
    o_state = w_mix ^ i_key;
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor, one round per enabled clock, stalling on round keys not yet done.
// Optional stall counter output enabled by defining AES_CIPHER_STALL_CNT_EN.
module aes_cipher_iter
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clk_en_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] plaintext_i,
  input  logic [127:0] round_keys_i [0:10],
  input  logic         round_keys_done_i [0:10],
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] ciphertext_o,
  output logic         busy_o
`ifdef AES_CIPHER_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt_o
`endif
);

  aes_fsm_e   r_fsm, w_fsm_nxt;
  aes_state_t r_state;
  logic [3:0] r_rnd;
  aes_state_t w_round;
  logic       w_key_ok, w_last, w_accept;

  assign w_key_ok = round_keys_done_i[r_rnd];
  assign w_last   = (r_rnd == 4'(NR));
  assign w_accept = in_valid_i & in_ready_o;

  assign in_ready_o   = (r_fsm == IDLE) & round_keys_done_i[0];
  assign out_valid_o  = (r_fsm == DONE);
  assign busy_o       = (r_fsm != IDLE);
  assign ciphertext_o = r_state;

  aes_round u_round (
    .i_state (r_state),
    .i_key   (round_keys_i[r_rnd]),
    .i_last  (w_last),
    .o_state (w_round)
  );

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (w_accept) w_fsm_nxt = ROUND;
      ROUND:   if (w_key_ok && w_last) w_fsm_nxt = DONE;
      DONE:    if (out_ready_i) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_rnd   <= '0;
    end else if (clk_en_i) begin
      r_fsm <= w_fsm_nxt;
      if (r_fsm == IDLE && w_accept) begin
        r_state <= plaintext_i ^ round_keys_i[0];
        r_rnd   <= 4'd1;
      end else if (r_fsm == ROUND && w_key_ok) begin
        r_state <= w_round;
        if (!w_last) r_rnd <= r_rnd + 4'd1;
      end
    end
  end

`ifdef AES_CIPHER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  assign stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (clk_en_i) begin
      if (r_fsm == IDLE && w_accept)
        r_stall_cnt <= '0;
      else if (r_fsm == ROUND && !w_key_ok && r_stall_cnt != 16'hffff)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
